// File: rtl/sdspi_burst.sv
// SPI master that runs multi-byte bursts with a selectable mode and SCLK divider.
// Commands are taken only while idle, except ABORT, which cuts a running burst short.
module sdspi_burst #(
    parameter int               DIV_W    = 10,
    parameter logic [DIV_W-1:0] SLOW_DIV = 10'd62,
    parameter logic [DIV_W-1:0] FAST_DIV = 10'd1,
    parameter int               NCS      = 1,
    parameter int               LEN_W    = 10,
    localparam int              CSW      = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       cmd,
    input  logic             cmd_valid,
    input  logic [CSW-1:0]   cs_sel,
    input  logic [1:0]       mode,
    input  logic [LEN_W-1:0] xfer_len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso,
    output logic [NCS-1:0]   spi_cs_n
);

    localparam logic [2:0] CMD_CSL   = 3'd1;
    localparam logic [2:0] CMD_CSH   = 3'd2;
    localparam logic [2:0] CMD_FAST  = 3'd3;
    localparam logic [2:0] CMD_SLOW  = 3'd4;
    localparam logic [2:0] CMD_XFER  = 3'd5;
    localparam logic [2:0] CMD_ABORT = 3'd6;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] LEAD  = 3'd2;
    localparam logic [2:0] TRAIL = 3'd3;
    localparam logic [2:0] GUARD = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] divReg;
    logic [DIV_W:0]   cnt;
    logic [2:0]       bitCnt;
    logic [LEN_W-1:0] remLen;
    logic [1:0]       modeReg;
    logic [7:0]       txShift;
    logic [7:0]       rxShift;
    logic [7:0]       rxByte;
    logic             cpol;
    logic             cpha;
    logic             halfEnd;
    logic             guardEnd;
    logic             abortReq;
    logic             sampleNow;

    always_comb begin
        cpol      = modeReg[1];
        cpha      = modeReg[0];
        halfEnd   = (cnt == {1'b0, divReg});
        guardEnd  = (cnt == {divReg, 1'b1});
        abortReq  = cmd_valid && (cmd == CMD_ABORT) && (state != IDLE);
        // One edge per bit both samples MISO and advances MOSI; which edge depends on CPHA.
        sampleNow = halfEnd && (cpha ? (state == TRAIL) : (state == LEAD));
        rxByte    = cpha ? {rxShift[6:0], spi_miso} : rxShift;
    end

    always_comb begin
        busy     = (state != IDLE);
        tx_ready = (state == LOAD) && tx_valid && !abortReq;
        spi_sclk = (state == LEAD) ? ~cpol : cpol;
        spi_mosi = 1'b1;
        if ((state == LEAD) || (state == TRAIL)) begin
            spi_mosi = txShift[7];
        end else if ((state == LOAD) && !cpha && tx_valid) begin
            spi_mosi = tx_data[7];
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            txShift <= tx_valid ? tx_data : 8'hFF;
        end else if (sampleNow) begin
            txShift <= {txShift[6:0], 1'b1};
        end
        if (sampleNow) begin
            rxShift <= {rxShift[6:0], spi_miso};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            divReg   <= SLOW_DIV;
            cnt      <= '0;
            bitCnt   <= '0;
            remLen   <= '0;
            modeReg  <= 2'b00;
            spi_cs_n <= '1;
            rx_data  <= 8'hFF;
            rx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (abortReq) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            case (cmd)
                                CMD_CSL, CMD_CSH: begin
                                    for (int i = 0; i < NCS; i++) begin
                                        if (32'(cs_sel) == i) spi_cs_n[i] <= (cmd == CMD_CSH);
                                    end
                                end
                                CMD_FAST: divReg <= FAST_DIV;
                                CMD_SLOW: divReg <= SLOW_DIV;
                                CMD_XFER: begin
                                    modeReg <= mode;
                                    remLen  <= xfer_len;
                                    state   <= LOAD;
                                end
                                default: ;
                            endcase
                        end
                    end
                    LOAD: begin
                        cnt    <= '0;
                        bitCnt <= '0;
                        state  <= LEAD;
                    end
                    LEAD: begin
                        if (halfEnd) begin
                            cnt   <= '0;
                            state <= TRAIL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    TRAIL: begin
                        if (halfEnd) begin
                            cnt    <= '0;
                            bitCnt <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                rx_data  <= rxByte;
                                rx_valid <= 1'b1;
                                if (remLen == '0) begin
                                    state <= GUARD;
                                end else begin
                                    remLen <= remLen - 1'b1;
                                    state  <= LOAD;
                                end
                            end else begin
                                state <= LEAD;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GUARD: begin
                        if (guardEnd) begin
                            cnt   <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdspi_burst.sv
// Bench for sdspi_burst: table of bursts checked through an rx scoreboard, plus
// hand-written abort, chip-select and asynchronous-reset sequences.
module tb_sdspi_burst;

    localparam int FAST_D = 1;
    localparam int SLOW_D = 62;
    localparam logic [2:0] CMD_CSL   = 3'd1;
    localparam logic [2:0] CMD_CSH   = 3'd2;
    localparam logic [2:0] CMD_FAST  = 3'd3;
    localparam logic [2:0] CMD_SLOW  = 3'd4;
    localparam logic [2:0] CMD_XFER  = 3'd5;
    localparam logic [2:0] CMD_ABORT = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic [0:0] cs_sel = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [9:0] xfer_len = 10'd0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [0:0] spi_cs_n;

    logic       misoSel = 1'b0;
    logic       patBit = 1'b1;
    logic [7:0] misoPat = 8'h00;
    logic       curCpol = 1'b0;

    assign spi_miso = misoSel ? patBit : spi_mosi;

    always #5 clk = ~clk;

    sdspi_burst dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cs_sel(cs_sel),
        .mode(mode), .xfer_len(xfer_len), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .done(done), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_n(spi_cs_n)
    );

    // Monitor: samples 1 time unit after each rising edge and owns all its counters.
    logic [7:0] expQ[$];
    int popIdx = 0, rxBad = 0, rxExtra = 0, rxCnt = 0, txReadyCnt = 0, doneCnt = 0;
    int cyc = 0, leadIdx = 0, leadStart = 0, leadMin = 1000000, leadMax = 0;
    int lastRxCyc = 0, doneLat = 0;
    logic [7:0] mosiCap = 8'h00;
    logic prevSclk = 1'b0, prevBusy = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (busy && !prevBusy) begin
            leadIdx = 0; leadMin = 1000000; leadMax = 0; mosiCap = 8'h00;
        end
        if (spi_sclk !== prevSclk) begin
            if (spi_sclk !== curCpol) begin
                leadStart = cyc;
                mosiCap   = {mosiCap[6:0], spi_mosi};
                patBit    = misoPat[3'(7 - (leadIdx % 8))];
                leadIdx++;
            end else if (leadIdx > 0) begin
                if (cyc - leadStart < leadMin) leadMin = cyc - leadStart;
                if (cyc - leadStart > leadMax) leadMax = cyc - leadStart;
            end
        end
        if (tx_ready) txReadyCnt++;
        if (rx_valid) begin
            rxCnt++;
            lastRxCyc = cyc;
            if (popIdx < expQ.size()) begin
                if (rx_data !== expQ[popIdx]) rxBad++;
                popIdx++;
            end else begin
                rxExtra++;
            end
        end
        if (done) begin
            doneCnt++;
            doneLat = cyc - lastRxCyc;
        end
        prevSclk = spi_sclk;
        prevBusy = busy;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cmdPulse(input logic [2:0] c, input logic [0:0] sel, input logic [1:0] m,
                            input logic [9:0] l);
        @(negedge clk);
        cmd = c; cmd_valid = 1'b1; cs_sel = sel; mode = m; xfer_len = l;
        @(negedge clk);
        cmd_valid = 1'b0; cmd = 3'd0;
    endtask

    typedef struct {
        logic       fast;
        logic [1:0] mode;
        logic [9:0] len;
        logic [7:0] tx;
        logic       txv;
        logic       usePat;
        logic [7:0] pat;
        logic [7:0] expRx;
        logic [7:0] expMosi;
    } vec_t;

    vec_t vecs[8];

    task automatic runBurst(input int idx, input vec_t v);
        int guard, div, nb, rxB, txB, doneB, badB;
        div = v.fast ? FAST_D : SLOW_D;
        nb  = int'(v.len) + 1;
        cmdPulse(v.fast ? CMD_FAST : CMD_SLOW, 1'b0, 2'b00, 10'd0);
        curCpol = v.mode[1]; tx_data = v.tx; tx_valid = v.txv;
        misoSel = v.usePat; misoPat = v.pat;
        rxB = rxCnt; txB = txReadyCnt; doneB = doneCnt; badB = rxBad;
        for (int b = 0; b < nb; b++) expQ.push_back(v.expRx);
        cmdPulse(CMD_XFER, 1'b0, v.mode, v.len);
        guard = 0;
        while (doneCnt == doneB && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("r%0d_done_seen", idx), doneCnt - doneB, 1);
        check($sformatf("r%0d_busy_idle", idx), busy, 0);
        check($sformatf("r%0d_sclk_idle", idx), spi_sclk, v.mode[1]);
        check($sformatf("r%0d_mosi_idle", idx), spi_mosi, 1);
        check($sformatf("r%0d_rx_count", idx), rxCnt - rxB, nb);
        check($sformatf("r%0d_rx_scoreboard", idx), rxBad - badB, 0);
        check($sformatf("r%0d_rx_data", idx), rx_data, v.expRx);
        check($sformatf("r%0d_tx_ready", idx), txReadyCnt - txB, v.txv ? nb : 0);
        check($sformatf("r%0d_lead_min", idx), leadMin, div + 1);
        check($sformatf("r%0d_lead_max", idx), leadMax, div + 1);
        check($sformatf("r%0d_done_latency", idx), doneLat, 2 * (div + 1));
        check($sformatf("r%0d_mosi_bits", idx), mosiCap, v.expMosi);
        repeat (3) @(negedge clk);
        check($sformatf("r%0d_done_once", idx), doneCnt - doneB, 1);
        misoSel = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int guard, rxB, doneB, badB;
        vecs[0] = '{1'b1, 2'b00, 10'd0, 8'hA5, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{1'b1, 2'b01, 10'd1, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{1'b1, 2'b10, 10'd0, 8'h81, 1'b1, 1'b0, 8'h00, 8'h81, 8'h81};
        vecs[3] = '{1'b1, 2'b11, 10'd2, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h5A, 8'h5A};
        vecs[4] = '{1'b0, 2'b11, 10'd2, 8'h00, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF};
        vecs[5] = '{1'b1, 2'b01, 10'd0, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'h00};
        vecs[6] = '{1'b1, 2'b00, 10'd0, 8'hFF, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'hFF};
        vecs[7] = '{1'b1, 2'b00, 10'd0, 8'h12, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF};

        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 1);
        check("rst_rx_data", rx_data, 8'hFF);
        check("rst_busy", busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_done", done, 0);
        tx_valid = 1'b0;

        cmdPulse(CMD_CSL, 1'b1, 2'b00, 10'd0);
        check("csl_sel_out_of_range", spi_cs_n, 1'b1);
        cmdPulse(CMD_CSL, 1'b0, 2'b00, 10'd0);
        check("csl_cs_n", spi_cs_n, 1'b0);
        check("csl_sclk", spi_sclk, 0);
        check("csl_mosi", spi_mosi, 1);
        check("csl_busy", busy, 0);
        cmdPulse(CMD_ABORT, 1'b0, 2'b00, 10'd0);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_cs_n", spi_cs_n, 1'b0);

        for (int i = 0; i < 8; i++) runBurst(i, vecs[i]);

        // Abort during bit 4 of byte 2 of a four-byte burst: only byte 1 may arrive.
        cmdPulse(CMD_FAST, 1'b0, 2'b00, 10'd0);
        curCpol = 1'b0; tx_data = 8'h96; tx_valid = 1'b1; misoSel = 1'b0;
        rxB = rxCnt; doneB = doneCnt; badB = rxBad;
        expQ.push_back(8'h96);
        cmdPulse(CMD_XFER, 1'b0, 2'b00, 10'd3);
        guard = 0;
        while (leadIdx < 13 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("abort_reached_bit4", leadIdx, 13);
        cmdPulse(CMD_ABORT, 1'b0, 2'b00, 10'd0);
        check("abort_busy", busy, 0);
        check("abort_sclk", spi_sclk, 0);
        check("abort_mosi", spi_mosi, 1);
        check("abort_cs_n", spi_cs_n, 1'b0);
        repeat (40) @(negedge clk);
        check("abort_rx_count", rxCnt - rxB, 1);
        check("abort_rx_scoreboard", rxBad - badB, 0);
        check("abort_no_done", doneCnt - doneB, 0);
        check("abort_still_idle", busy, 0);

        cmdPulse(CMD_CSH, 1'b0, 2'b00, 10'd0);
        check("csh_cs_n", spi_cs_n, 1'b1);

        // CSL while busy is ignored; then asynchronous reset mid-byte.
        cmdPulse(CMD_SLOW, 1'b0, 2'b00, 10'd0);
        curCpol = 1'b1; tx_valid = 1'b0;
        rxB = rxCnt; doneB = doneCnt;
        cmdPulse(CMD_XFER, 1'b0, 2'b11, 10'd1);
        repeat (5) @(negedge clk);
        check("busy_during_burst", busy, 1);
        cmdPulse(CMD_CSL, 1'b0, 2'b00, 10'd0);
        check("csl_busy_ignored", spi_cs_n, 1'b1);
        guard = 0;
        while (leadIdx < 3 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("arst_reached_bit2", leadIdx, 3);
        repeat (70) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cs_n", spi_cs_n, 1'b1);
        check("arst_sclk", spi_sclk, 0);
        check("arst_mosi", spi_mosi, 1);
        check("arst_rx_data", rx_data, 8'hFF);
        check("arst_busy", busy, 0);
        check("arst_tx_ready", tx_ready, 0);
        check("arst_rx_valid", rx_valid, 0);
        check("arst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("arst_no_rx", rxCnt - rxB, 0);
        check("arst_no_done", doneCnt - doneB, 0);
        check("arst_idle_sclk", spi_sclk, 0);
        check("no_unexpected_rx", rxExtra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
